op_encoder: RTL and testbench

- Inverse of the opcode control decoder: takes (ALUOp, RegWrite) control requests and re-encodes them into 4-bit opcodes.
- Buffers requests in a small FIFO and issues opcodes toward the decoder/instruction path over a valid/ready handshake.
- Used by instruction-generation logic and test sequencers that work at the control level but must feed the opcode-level datapath.

---
 rtl/op_encoder.sv | 106 ++++++++++
 tb/tb_op_encoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/op_encoder.sv
// Re-encodes (ALUOp, RegWrite) control requests into 4-bit opcodes, buffers them
// in a small FIFO and issues them through a registered output slot.
module op_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_aluop,
    input  logic             in_regwrite,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_opcode,
    output logic             illegal,
    output logic [CNT_W-1:0] issued_cnt,
    input  logic             flush
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid holds its payload stable until that edge, and ready never depends on valid.

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          wr_en;
    logic          rd_en;
    logic          slot_take;
    logic          req_illegal;
    logic [3:0]    enc_opcode;

    // Register-writing ops map to aluop+1 so that 0000 stays reserved for NOP.
    always_comb begin
        enc_opcode  = 4'b0000;
        req_illegal = 1'b0;
        if (in_regwrite) begin
            enc_opcode = {1'b0, in_aluop} + 4'd1;
        end else if (in_aluop != 3'b000) begin
            req_illegal = 1'b1;
        end
    end

    assign in_ready  = (count < FULL);
    assign wr_en     = in_valid && in_ready && !flush;
    assign slot_take = !out_valid || out_ready;
    assign rd_en     = (count != '0) && slot_take && !flush;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= enc_opcode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output slot: refills from the FIFO head whenever it is empty or being taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_opcode <= 4'b0000;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_opcode <= 4'b0000;
        end else if (slot_take) begin
            if (count != '0) begin
                out_valid  <= 1'b1;
                out_opcode <= mem[rd_ptr];
            end else begin
                out_valid  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_cnt <= '0;
            illegal    <= 1'b0;
        end else begin
            if (!flush && out_valid && out_ready) issued_cnt <= issued_cnt + 1'b1;
            if (wr_en && req_illegal) illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_op_encoder.sv
// Self-checking bench for op_encoder: directed scenarios plus random traffic checked
// against a queue-based reference of the encoder's externally visible behaviour.
module tb_op_encoder;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_aluop = 3'b000;
    logic             in_regwrite = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [3:0]       out_opcode;
    logic             illegal;
    logic [CNT_W-1:0] issued_cnt;
    logic             flush = 1'b0;

    op_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_aluop(in_aluop), .in_regwrite(in_regwrite),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .illegal(illegal), .issued_cnt(issued_cnt), .flush(flush)
    );

    always #5 clk = ~clk;

    // Reference state: every accepted-but-not-issued opcode in order, plus occupancy split.
    logic [3:0]       exp_q[$];
    int               m_fifo = 0;
    bit               m_slot = 0;
    bit               m_illegal = 0;
    logic [CNT_W-1:0] m_issued = '0;
    int               checks = 0;
    int               errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_op(input logic [2:0] op, input logic rw);
        if (rw) return 4'(int'(op) + 1);
        return 4'd0;
    endfunction

    // One clock: check registered outputs against the model, advance the model, take the edge.
    task automatic cycle();
        bit fire_in;
        bit fire_out;
        check("in_ready", in_ready, m_fifo < DEPTH);
        check("out_valid", out_valid, m_slot);
        check("issued_cnt", issued_cnt, m_issued);
        check("illegal", illegal, m_illegal);
        fire_in  = in_valid && (m_fifo < DEPTH);
        fire_out = m_slot && out_ready;
        if (fire_out && !flush) check("out_opcode", out_opcode, exp_q.size() ? exp_q[0] : 4'hx);
        if (flush) begin
            exp_q.delete();
            m_fifo = 0;
            m_slot = 0;
        end else begin
            if (fire_out) begin
                void'(exp_q.pop_front());
                m_issued++;
            end
            if (m_fifo > 0 && (!m_slot || out_ready)) begin
                m_fifo--;
                m_slot = 1;
            end else if (fire_out) begin
                m_slot = 0;
            end
            if (fire_in) begin
                exp_q.push_back(ref_op(in_aluop, in_regwrite));
                m_fifo++;
                if (!in_regwrite && in_aluop != 3'b000) m_illegal = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_fifo = 0;
        m_slot = 0;
        m_illegal = 0;
        m_issued = '0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() > 0 || m_slot); i++) cycle();
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic set_req(input logic [2:0] op, input logic rw);
        in_valid    = 1'b1;
        in_aluop    = op;
        in_regwrite = rw;
    endtask

    logic [3:0]       held;
    logic [CNT_W-1:0] base;
    int               waited;

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_opcode", out_opcode, 0);
        check("rst_illegal", illegal, 0);
        check("rst_issued", issued_cnt, 0);
        check("rst_in_ready", in_ready, 1);

        // Single request: visible after the second edge, counted after the third
        out_ready = 1'b1;
        set_req(3'b010, 1'b1);
        cycle();
        in_valid = 1'b0;
        check("lat_not_yet", out_valid, 0);
        cycle();
        check("lat_valid", out_valid, 1);
        check("lat_opcode", out_opcode, 4'b0011);
        cycle();
        check("lat_issued", issued_cnt, 1);
        check("lat_illegal", illegal, 0);
        drain();

        // Sweep all ALU ops then a NOP, back-to-back
        base = m_issued;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) set_req(3'(i), 1'b1);
            else set_req(3'b000, 1'b0);
            check("sweep_ready", in_ready, 1);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        cycle();
        check("sweep_issued", issued_cnt, base + 8'd9);
        drain();

        // Backpressure: FIFO plus slot hold five requests
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_req(3'(k + 1), 1'b1);
            cycle();
        end
        check("bp_full", in_ready, 0);
        check("bp_slot", out_opcode, 4'b0010);
        held = out_opcode;
        set_req(3'b111, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("bp_stable", out_opcode, held);
        end
        out_ready = 1'b1;
        waited = 0;
        while (!in_ready && waited < 10) begin
            cycle();
            waited++;
        end
        check("bp_release", in_ready, 1);
        cycle();
        drain();

        // Illegal request encodes as NOP and sets the sticky flag
        set_req(3'b101, 1'b0);
        cycle();
        in_valid = 1'b0;
        cycle();
        check("ill_opcode", out_opcode, 4'b0000);
        check("ill_flag", illegal, 1);
        drain();

        // Flush with one in the slot and three queued, concurrent write dropped
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_req(3'(k), 1'b1);
            cycle();
        end
        check("fl_pre_valid", out_valid, 1);
        base = m_issued;
        out_ready = 1'b1;
        flush = 1'b1;
        set_req(3'b011, 1'b1);
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_opcode", out_opcode, 0);
        check("fl_issued", issued_cnt, base);
        check("fl_illegal_kept", illegal, 1);
        for (int k = 0; k < 3; k++) cycle();
        set_req(3'b001, 1'b1);
        cycle();
        drain();
        check("ill_after_legal", illegal, 1);

        // Async reset between edges while streaming
        set_req(3'b100, 1'b1);
        for (int k = 0; k < 4; k++) cycle();
        #3 rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_issued", issued_cnt, 0);
        check("arst_illegal", illegal, 0);
        in_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) cycle();
        check("arst_no_stale", out_valid, 0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_aluop    = 3'($urandom_range(0, 7));
            in_regwrite = ($urandom_range(0, 7) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 59) == 0);
            cycle();
        end
        flush = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
